// File: rtl/cas_ddram_loader_if.sv
// DDRAM command/data bus between the CAS loader and the memory arbiter.
// master: loader side (drives commands); slave: memory side.
interface cas_ddram_loader_if;
   logic        DDRAM_CLK;
   logic        DDRAM_BUSY;
   logic [7:0]  DDRAM_BURSTCNT;
   logic [28:0] DDRAM_ADDR;
   logic [63:0] DDRAM_DOUT;
   logic        DDRAM_DOUT_READY;
   logic        DDRAM_RD;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;
   logic        DDRAM_WE;

   modport master (
      output DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR,
      output DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE,
      input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
   );

   modport slave (
      input  DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR,
      input  DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE,
      output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
   );
endinterface

// File: rtl/cas_ddram_loader.sv
// CAS image loader: packs tape download bytes into DDRAM words and serves
// byte reads via a one-word cache. Ports: clk/reset, ioctl_*, rd_*, ddr bus.
module cas_ddram_loader #(
   parameter logic [28:0] BASE_ADDR = 29'h0600000,
   parameter logic [7:0]  DL_INDEX  = 8'd2
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        rd_req_i,
   input  logic [24:0] rd_addr_i,
   output logic [7:0]  rd_data_o,
   output logic        rd_valid_o,
   output logic        busy_o,
   output logic [24:0] length_o,
   output logic        overflow_o,
   cas_ddram_loader_if.master ddr
);
   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_CMD, S_RD_WAIT, S_RD_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        dl_q;
   logic        stg_vld_q, stg_vld_d;
   logic [21:0] stg_word_q, stg_word_d;
   logic [63:0] stg_data_q, stg_data_d;
   logic [7:0]  stg_be_q, stg_be_d;
   logic        slt_vld_q, slt_vld_d;
   logic [21:0] slt_word_q, slt_word_d;
   logic [63:0] slt_data_q, slt_data_d;
   logic [7:0]  slt_be_q, slt_be_d;
   logic        pend_q, pend_d;
   logic [24:0] len_q, len_d;
   logic        ovf_q, ovf_d;
   logic        c_vld_q, c_vld_d;
   logic [21:0] c_word_q, c_word_d;
   logic [63:0] c_data_q, c_data_d;
   logic [24:0] ra_q, ra_d;
   logic        rp_q, rp_d;
   logic        rv_q, rv_d;
   logic [7:0]  rd_q, rd_d;

   logic        dl_act, rise, fall, strobe, acc, slot_ld, rd_ok;
   logic [25:0] nxt_len;
   logic [24:0] rw;

   assign dl_act = ioctl_download && (ioctl_index == DL_INDEX);
   assign rise   = dl_act && !dl_q;
   assign fall   = !dl_act && dl_q;
   assign strobe = ioctl_wr && dl_act;
   assign rd_ok  = (state_q == S_IDLE) && !dl_act && !slt_vld_q
                   && !rp_q && rd_req_i;

   always_comb begin
      state_d    = state_q;
      stg_vld_d  = stg_vld_q;
      stg_word_d = stg_word_q;
      stg_data_d = stg_data_q;
      stg_be_d   = stg_be_q;
      slt_vld_d  = slt_vld_q;
      slt_word_d = slt_word_q;
      slt_data_d = slt_data_q;
      slt_be_d   = slt_be_q;
      pend_d     = pend_q;
      len_d      = len_q;
      ovf_d      = ovf_q;
      c_vld_d    = c_vld_q;
      c_word_d   = c_word_q;
      c_data_d   = c_data_q;
      ra_d       = ra_q;
      rp_d       = rp_q;
      rv_d       = 1'b0;
      rd_d       = rd_q;
      acc        = 1'b0;
      slot_ld    = 1'b0;
      nxt_len    = {1'b0, ioctl_addr} + 26'd1;
      rw         = rd_ok ? rd_addr_i : ra_q;

      // A new session starts from an empty stage; the slot keeps draining.
      if (rise) begin
         stg_vld_d = 1'b0;
         len_d     = '0;
         ovf_d     = 1'b0;
         pend_d    = 1'b0;
      end

      if (strobe) begin
         if (!stg_vld_d || stg_word_d == ioctl_addr[24:3]) begin
            if (!stg_vld_d) begin
               stg_data_d = '0;
               stg_be_d   = '0;
            end
            acc = 1'b1;
         end else if (!slt_vld_q) begin
            slot_ld    = 1'b1;
            slt_word_d = stg_word_d;
            slt_data_d = stg_data_d;
            slt_be_d   = stg_be_d;
            stg_data_d = '0;
            stg_be_d   = '0;
            acc        = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
         if (acc) begin
            stg_vld_d  = 1'b1;
            stg_word_d = ioctl_addr[24:3];
            stg_data_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
            stg_be_d[ioctl_addr[2:0]] = 1'b1;
            if (nxt_len > {1'b0, len_d}) len_d = nxt_len[24:0];
         end
      end else if ((fall || pend_q) && stg_vld_d) begin
         // End-of-download flush waits here while the slot is occupied.
         if (!slt_vld_q) begin
            slot_ld    = 1'b1;
            slt_word_d = stg_word_d;
            slt_data_d = stg_data_d;
            slt_be_d   = stg_be_d;
            stg_vld_d  = 1'b0;
            pend_d     = 1'b0;
         end else begin
            pend_d = 1'b1;
         end
      end
      if (!stg_vld_d) pend_d = 1'b0;
      if (slot_ld) slt_vld_d = 1'b1;

      if (rd_ok) ra_d = rd_addr_i;

      unique case (state_q)
         S_IDLE: begin
            if (slt_vld_q) begin
               state_d = S_WR;
            end else if (rd_ok || rp_q) begin
               // A flush landing in the slot now must be written first.
               if (slot_ld) begin
                  rp_d = 1'b1;
               end else begin
                  rp_d = 1'b0;
                  if (c_vld_q && c_word_q == rw[24:3]) begin
                     rv_d = 1'b1;
                     rd_d = c_data_q[{rw[2:0], 3'b000} +: 8];
                  end else begin
                     state_d = S_RD_CMD;
                  end
               end
            end
         end
         S_WR: begin
            if (!ddr.DDRAM_BUSY) begin
               state_d   = S_IDLE;
               slt_vld_d = 1'b0;
               if (slt_word_q == c_word_q) c_vld_d = 1'b0;
            end
         end
         S_RD_CMD: begin
            if (!ddr.DDRAM_BUSY) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (ddr.DDRAM_DOUT_READY) begin
               c_vld_d  = 1'b1;
               c_word_d = ra_q[24:3];
               c_data_d = ddr.DDRAM_DOUT;
               rv_d     = 1'b1;
               rd_d     = ddr.DDRAM_DOUT[{ra_q[2:0], 3'b000} +: 8];
               state_d  = S_RD_DONE;
            end
         end
         S_RD_DONE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      if (rise) c_vld_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= S_IDLE;
         dl_q       <= 1'b0;
         stg_vld_q  <= 1'b0;
         stg_word_q <= '0;
         stg_data_q <= '0;
         stg_be_q   <= '0;
         slt_vld_q  <= 1'b0;
         slt_word_q <= '0;
         slt_data_q <= '0;
         slt_be_q   <= '0;
         pend_q     <= 1'b0;
         len_q      <= '0;
         ovf_q      <= 1'b0;
         c_vld_q    <= 1'b0;
         c_word_q   <= '0;
         c_data_q   <= '0;
         ra_q       <= '0;
         rp_q       <= 1'b0;
         rv_q       <= 1'b0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         dl_q       <= dl_act;
         stg_vld_q  <= stg_vld_d;
         stg_word_q <= stg_word_d;
         stg_data_q <= stg_data_d;
         stg_be_q   <= stg_be_d;
         slt_vld_q  <= slt_vld_d;
         slt_word_q <= slt_word_d;
         slt_data_q <= slt_data_d;
         slt_be_q   <= slt_be_d;
         pend_q     <= pend_d;
         len_q      <= len_d;
         ovf_q      <= ovf_d;
         c_vld_q    <= c_vld_d;
         c_word_q   <= c_word_d;
         c_data_q   <= c_data_d;
         ra_q       <= ra_d;
         rp_q       <= rp_d;
         rv_q       <= rv_d;
         rd_q       <= rd_d;
      end
   end

   assign rd_data_o  = rd_q;
   assign rd_valid_o = rv_q;
   assign busy_o     = (state_q != S_IDLE) || dl_act;
   assign length_o   = len_q;
   assign overflow_o = ovf_q;

   assign ddr.DDRAM_CLK      = clk_i;
   assign ddr.DDRAM_BURSTCNT = 8'd1;
   assign ddr.DDRAM_WE       = (state_q == S_WR);
   assign ddr.DDRAM_RD       = (state_q == S_RD_CMD);
   assign ddr.DDRAM_ADDR     =
      (state_q == S_WR)     ? BASE_ADDR + {7'd0, slt_word_q} :
      (state_q == S_RD_CMD) ? BASE_ADDR + {7'd0, ra_q[24:3]} : '0;
   assign ddr.DDRAM_DIN = (state_q == S_WR) ? slt_data_q : '0;
   assign ddr.DDRAM_BE  = (state_q == S_WR) ? slt_be_q : '0;
endmodule

// File: tb/tb_cas_ddram_loader.sv
// Bench for cas_ddram_loader: DDRAM memory model, image/cache reference
// model, directed scenarios and randomized download/read rounds.
module tb_cas_ddram_loader;
   localparam logic [28:0] BASE = 29'h0600000;

   logic        clk, rst_n;
   logic        dl, wr, rq;
   logic [7:0]  idx, wd;
   logic [24:0] wa, ra;
   logic [7:0]  rdata;
   logic        rvalid, busy, ovf;
   logic [24:0] len;

   cas_ddram_loader_if ddr();

   cas_ddram_loader #(.BASE_ADDR(BASE), .DL_INDEX(8'd2)) dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
      .ioctl_addr(wa), .ioctl_dout(wd),
      .rd_req_i(rq), .rd_addr_i(ra),
      .rd_data_o(rdata), .rd_valid_o(rvalid), .busy_o(busy),
      .length_o(len), .overflow_o(ovf),
      .ddr(ddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [63:0] mem [int];
   bit          wseen [int];
   logic [7:0]  img [int];
   int          maxlen;
   int          rd_lat = 2;
   int          busy_hold = 0;
   bit          rnd_busy = 1'b0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   logic [28:0] wl_addr [$];
   logic [63:0] wl_din [$];
   logic [7:0]  wl_be [$];
   logic [7:0]  exp_q [$];
   int          vcnt = 0;
   logic [7:0]  last_rd;
   bit          cache_ok = 1'b0;
   int          cache_word = 0;

   function automatic logic [63:0] mem_rd(input int w);
      logic [31:0] x;
      if (mem.exists(w)) return mem[w];
      x = w;
      return {x ^ 32'hC0DE_5A5A, ~x};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // DDRAM model: busy generation, write capture, delayed read replies.
   initial begin
      int cd, cw, w, run;
      logic b;
      logic [63:0] m;
      cd = 0; cw = 0; run = 0;
      ddr.DDRAM_BUSY = 1'b0;
      ddr.DDRAM_DOUT = '0;
      ddr.DDRAM_DOUT_READY = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            cd = 0; run = 0;
            ddr.DDRAM_BUSY = 1'b0;
            ddr.DDRAM_DOUT_READY = 1'b0;
            continue;
         end
         b = 1'b0;
         if (busy_hold > 0 && ddr.DDRAM_WE) begin
            b = 1'b1;
            busy_hold--;
         end else if (rnd_busy && run < 3) begin
            b = ($urandom_range(0, 2) == 0);
         end
         run = b ? run + 1 : 0;
         ddr.DDRAM_BUSY = b;
         ddr.DDRAM_DOUT_READY = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               ddr.DDRAM_DOUT_READY = 1'b1;
               ddr.DDRAM_DOUT = mem_rd(cw);
            end
         end
         if (!b && ddr.DDRAM_WE) begin
            w = int'(ddr.DDRAM_ADDR - BASE);
            m = mem_rd(w);
            for (int k = 0; k < 8; k++)
               if (ddr.DDRAM_BE[k]) m[k*8 +: 8] = ddr.DDRAM_DIN[k*8 +: 8];
            mem[w] = m;
            wseen[w] = 1'b1;
            wr_cnt++;
            wl_addr.push_back(ddr.DDRAM_ADDR);
            wl_din.push_back(ddr.DDRAM_DIN);
            wl_be.push_back(ddr.DDRAM_BE);
         end
         if (!b && ddr.DDRAM_RD) begin
            cw = int'(ddr.DDRAM_ADDR - BASE);
            cd = rd_lat;
            rd_cnt++;
         end
      end
   end

   // Per-cycle compare: held write commands and read completions.
   initial begin
      logic        pwe;
      logic [28:0] pa;
      logic [63:0] pd;
      logic [7:0]  pb, e;
      pwe = 1'b0; pa = '0; pd = '0; pb = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pwe = 1'b0;
            continue;
         end
         if (pwe && ddr.DDRAM_BUSY) begin
            chk("we_hold", {ddr.DDRAM_WE, ddr.DDRAM_ADDR, ddr.DDRAM_BE},
                {1'b1, pa, pb});
            chk("din_hold", ddr.DDRAM_DIN, pd);
         end
         pwe = ddr.DDRAM_WE;
         pa = ddr.DDRAM_ADDR;
         pd = ddr.DDRAM_DIN;
         pb = ddr.DDRAM_BE;
         if (rvalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_valid: got data %h want no valid",
                        rdata);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", rdata, e);
            end
            last_rd = rdata;
            vcnt++;
         end
      end
   end

   task automatic chk_zero(input string nm);
      chk({nm, "_st"}, {rdata, rvalid, busy, len, ovf}, '0);
      chk({nm, "_cmd"},
          {ddr.DDRAM_WE, ddr.DDRAM_RD, ddr.DDRAM_ADDR, ddr.DDRAM_BE}, '0);
      chk({nm, "_din"}, ddr.DDRAM_DIN, '0);
      chk({nm, "_bcnt"}, ddr.DDRAM_BURSTCNT, 64'd1);
   endtask

   task automatic dl_start();
      @(negedge clk);
      idx = 8'd2;
      dl = 1'b1;
      cache_ok = 1'b0;
      img.delete();
      maxlen = 0;
   endtask

   task automatic dl_byte(input logic [24:0] a, input logic [7:0] d,
                          input bit keep);
      @(negedge clk);
      wr = 1'b1; wa = a; wd = d;
      if (keep) begin
         img[int'(a)] = d;
         if (int'(a) + 1 > maxlen) maxlen = int'(a) + 1;
      end
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic dl_end();
      @(negedge clk);
      dl = 1'b0;
   endtask

   task automatic drain();
      int q, n;
      q = 0; n = 0;
      while (q < 12 && n < 1000) begin
         @(negedge clk);
         #2;
         n++;
         if (!ddr.DDRAM_WE && !ddr.DDRAM_RD && !busy) q++;
         else q = 0;
      end
      checks++;
      if (q < 12) begin
         errors++;
         $display("FAIL drain_timeout: got busy after %0d want idle", n);
      end
   endtask

   task automatic check_image(input string nm);
      int bad, ba;
      logic [63:0] m;
      logic [7:0] g, x;
      bad = 0; ba = 0; g = '0; x = '0;
      foreach (img[a]) begin
         m = mem_rd(a >> 3);
         if (m[(a % 8) * 8 +: 8] !== img[a]) begin
            if (bad == 0) begin
               ba = a; g = m[(a % 8) * 8 +: 8]; x = img[a];
            end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: addr %0d got %h want %h (%0d bad)",
                  nm, ba, g, x, bad);
      end
   endtask

   task automatic do_read(input logic [24:0] a, input int lat);
      logic [63:0] m;
      int w, r0, v0, n;
      bit hit;
      w = int'(a >> 3);
      rd_lat = lat;
      m = mem_rd(w);
      exp_q.push_back(m[int'(a[2:0]) * 8 +: 8]);
      hit = cache_ok && cache_word == w;
      r0 = rd_cnt;
      v0 = vcnt;
      @(negedge clk);
      rq = 1'b1;
      ra = a;
      n = 0;
      do begin
         @(negedge clk);
         rq = 1'b0;
         #2;
         n++;
      end while (vcnt == v0 && n < 300);
      if (vcnt == v0) begin
         checks++;
         errors++;
         $display("FAIL rd_timeout: got no valid want valid addr %h", a);
         exp_q.delete();
         return;
      end
      if (hit) begin
         chk("hit_lat", n, 64'd1);
         chk("hit_no_rd", rd_cnt - r0, 64'd0);
      end else begin
         chk("miss_rd", rd_cnt - r0, 64'd1);
      end
      cache_ok = 1'b1;
      cache_word = w;
   endtask

   initial begin
      int w0, nb;
      logic [24:0] a, pa;
      dl = 0; wr = 0; rq = 0; idx = 0; wd = 0; wa = 0; ra = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 chk_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First load: one full word.
      w0 = wr_cnt;
      wl_addr.delete(); wl_din.delete(); wl_be.delete();
      dl_start();
      for (int i = 0; i < 8; i++) dl_byte(25'(i), 8'(8'h11 + i), 1'b1);
      dl_end();
      drain();
      chk("t1_wcnt", wr_cnt - w0, 64'd1);
      chk("t1_addr", wl_addr[0], 64'h0600000);
      chk("t1_din", wl_din[0], 64'h1817161514131211);
      chk("t1_be", wl_be[0], 64'hFF);
      chk("t1_len", len, 64'd8);
      check_image("t1_img");

      // Miss then hit in the same word.
      do_read(25'd3, 4);
      chk("t4_a3", last_rd, 64'h14);
      do_read(25'd6, 2);
      chk("t4_a6", last_rd, 64'h17);

      // Write held by a busy memory.
      dl_start();
      for (int i = 24; i < 32; i++) dl_byte(25'(i), 8'($urandom), 1'b1);
      busy_hold = 5;
      w0 = wr_cnt;
      dl_end();
      drain();
      chk("t3_wcnt", wr_cnt - w0, 64'd1);
      chk("t3_hold_used", busy_hold, 64'd0);
      check_image("t3_img");

      // Strobe without an active download is ignored.
      @(negedge clk);
      idx = 8'd2; wr = 1'b1; wa = 25'h200; wd = 8'h3C;
      @(negedge clk);
      wr = 1'b0;
      drain();
      chk("stray_absent", wseen.exists(64), 64'd0);
      chk("stray_len", len, 64'd32);

      // Two partial words.
      w0 = wr_cnt;
      wl_addr.delete(); wl_din.delete(); wl_be.delete();
      dl_start();
      dl_byte(25'd5, 8'hA5, 1'b1);
      dl_byte(25'd9, 8'h5A, 1'b1);
      dl_end();
      drain();
      chk("t2_wcnt", wr_cnt - w0, 64'd2);
      chk("t2_be0", wl_be[0], 64'h20);
      chk("t2_addr0", wl_addr[0], 64'h0600000);
      chk("t2_d0", wl_din[0][47:40], 64'hA5);
      chk("t2_be1", wl_be[1], 64'h02);
      chk("t2_addr1", wl_addr[1], 64'h0600001);
      chk("t2_d1", wl_din[1][15:8], 64'h5A);
      chk("t2_len", len, 64'd10);
      check_image("t2_img");

      // Overflow: slot stuck busy, third word dropped.
      dl_start();
      busy_hold = 60;
      dl_byte(25'h100, 8'hC1, 1'b1);
      dl_byte(25'h108, 8'hC2, 1'b1);
      dl_byte(25'h110, 8'h77, 1'b0);
      chk("t5_ovf", ovf, 64'd1);
      chk("t5_len", len, 64'h109);
      dl_end();
      drain();
      chk("t5_drop_absent", wseen.exists(34), 64'd0);
      check_image("t5_img");
      dl_start();
      @(negedge clk);
      #2 chk("t5_ovf_clr", ovf, 64'd0);
      dl_end();
      drain();

      // Randomized download and read rounds.
      for (int r = 0; r < 3; r++) begin
         rnd_busy = 1'b1;
         dl_start();
         nb = $urandom_range(20, 40);
         for (int i = 0; i < nb; i++) begin
            dl_byte(25'($urandom_range(0, 63)), 8'($urandom), 1'b1);
            repeat ($urandom_range(8, 12)) @(negedge clk);
         end
         dl_end();
         drain();
         chk("rnd_len", len, 64'(maxlen));
         chk("rnd_ovf", ovf, 64'd0);
         check_image("rnd_img");
         pa = '0;
         for (int i = 0; i < 12; i++) begin
            if (i > 0 && $urandom_range(0, 1) == 1)
               a = (pa & ~25'h7) | 25'($urandom_range(0, 7));
            else
               a = 25'($urandom_range(0, 127));
            do_read(a, $urandom_range(1, 6));
            pa = a;
         end
      end
      rnd_busy = 1'b0;

      // Reset while a read waits for data.
      do_read(25'h10, 2);
      rd_lat = 20;
      @(negedge clk);
      rq = 1'b1;
      ra = 25'h30;
      @(negedge clk);
      rq = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_busy", busy, 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_zero("t6_rst");
      exp_q.delete();
      cache_ok = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      w0 = rd_cnt;
      do_read(25'h12, 2);
      chk("t6_refetch", rd_cnt - w0, 64'd1);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cas_ddram_loader.md
Name: cas_ddram_loader

Overview:
- Buffers a cassette (CAS) image from the HPS download stream into DDR3 and serves byte reads back to the tape player inside the Sord M5 core.
- Upstream side: packs ioctl bytes of the tape download (index DL_INDEX) into 64-bit DDRAM word writes with byte enables.
- Downstream side: a request/valid byte-read port backed by a one-word read cache. Drives the DDRAM_* pins the core exports.

Parameters:
BASE_ADDR, 29'h0600000, DDRAM 64-bit word address where byte 0 of the image lives
DL_INDEX, 8'd2, ioctl_index value that selects the tape download

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
ioctl_download  in  1  download in progress
ioctl_index  in  8  download slot index
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte address within the image
ioctl_dout  in  8  byte data
rd_req_i  in  1  one-cycle byte read request
rd_addr_i  in  25  byte address to read
rd_data_o  out  8  read byte, valid while rd_valid_o=1
rd_valid_o  out  1  one-cycle read completion strobe
busy_o  out  1  FSM not IDLE, or download active
length_o  out  25  image length in bytes (highest written address + 1)
overflow_o  out  1  sticky: a byte was dropped because the write slot was full
DDRAM_CLK  out  1  equals clk_i
DDRAM_BUSY  in  1  DDRAM not accepting commands
DDRAM_BURSTCNT  out  8  always 1
DDRAM_ADDR  out  29  BASE_ADDR + word index
DDRAM_DOUT  in  64  read data
DDRAM_DOUT_READY  in  1  read data strobe
DDRAM_RD  out  1  read command
DDRAM_DIN  out  64  write data
DDRAM_BE  out  8  write byte enables
DDRAM_WE  out  1  write command

Behaviour:
- Reset (async, immediate):
  - All outputs are 0, except DDRAM_BURSTCNT=1 and DDRAM_CLK.
  - Stage empty, write slot empty, cache invalid, FSM IDLE.
  - A command in flight is abandoned. No recovery is attempted.
- Active strobe: ioctl_wr & ioctl_download & ioctl_index==DL_INDEX. All other strobes are ignored.
- Rising edge of the qualified download:
  - Clear overflow_o, length_o, stage, and the cache valid bit.
  - The write slot is not cleared; a pending write completes.
- Packing:
  - Word index = ioctl_addr[24:3]. Lane k = ioctl_addr[2:0]; data goes to DIN[8k+7:8k] (little-endian), and BE bit k is set.
  - Strobe for the stage's current word: merge into the stage.
  - Strobe for a different word while the stage is non-empty:
    - If the slot is empty: move the stage to the slot, then load the new byte into a fresh stage, in the same cycle.
    - If the slot is full: drop the byte and set overflow_o.
  - On every accepted strobe, length_o <= max(length_o, ioctl_addr+1).
- Falling edge of download: move a non-empty stage to the slot. If the slot is full, hold the stage and move it on the first cycle the slot frees.
- FSM states: IDLE, WR, RD_CMD, RD_WAIT, RD_DONE.
- IDLE:
  - Slot full -> WR. Writes have priority over reads.
  - Otherwise an accepted rd_req_i -> cache check.
- WR:
  - Assert DDRAM_WE with DDRAM_ADDR/DIN/BE from the slot, held stable.
  - The command is accepted at the first posedge with DDRAM_BUSY=0.
  - Next cycle: WE=0, slot freed, IDLE.
  - If the slot's word equals the cached word, the cache is invalidated.
- Read acceptance:
  - rd_req_i is accepted only in IDLE with download inactive and the slot empty.
  - Otherwise it is ignored: no rd_valid_o.
  - rd_addr_i is latched on acceptance.
- Cache hit (valid and same word): rd_valid_o=1 and rd_data_o = the cached lane on the next cycle (latency 1). Stay IDLE.
- Cache miss, RD_CMD:
  - DDRAM_RD=1, ADDR = BASE_ADDR + word.
  - Held until a posedge with DDRAM_BUSY=0, then RD=0 -> RD_WAIT.
- RD_WAIT: on DDRAM_DOUT_READY, capture DOUT into the cache, set valid, record the word -> RD_DONE.
- RD_DONE: rd_valid_o=1 for one cycle with the latched lane -> IDLE.
- Simultaneous write and read on the same word in IDLE: the write goes first. The read waits and re-checks the cache afterwards.
- Reads beyond length_o are not checked. They return DDRAM contents.
- Address arithmetic: 29-bit, wraps modulo 2^29.

Test Plan:
- Download bytes 0x11..0x18 to addresses 0..7, then drop download -> exactly one WE, ADDR=0x0600000, DIN=0x1817161514131211, BE=0xFF, length_o=8.
- Write bytes to addresses 5 and 9, then end download -> two writes: word0 BE=0x20, and word1 BE=0x02 with data at DIN[15:8]; length_o=10.
- Hold DDRAM_BUSY=1 for 5 cycles during WR -> WE and ADDR/DIN/BE stable throughout; exactly one accepted write.
- After the first load, read address 3 with DOUT_READY 4 cycles after RD acceptance -> rd_data_o=0x14. Then read address 6 -> rd_valid_o 1 cycle after rd_req_i, 0x17, no DDRAM_RD.
- Force the slot full (BUSY=1) and strobe a byte for a third word -> overflow_o=1 and the byte is absent. A new download start clears overflow_o.
- Assert reset_n_i=0 mid-RD_WAIT -> all outputs 0 asynchronously. After release, a read of a previously cached word issues DDRAM_RD (cache invalid).
